// File: rtl/maxnet_controller.sv
// Sequencing FSM for the Maxnet winner-take-all datapath: load, then check/iterate until one or no survivors.
// Optional iteration limit enabled by defining MAXNET_CTRL_TIMEOUT_EN.
module maxnet_controller #(
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = 2,
  parameter int ITER_W      = 8,
  parameter int MAX_ITER    = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_NEURONS-1:0] nonzero,
  output logic                   load_init,
  output logic                   init_sel,
  output logic                   load_iter,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W-1:0]       winner,
  output logic                   winner_valid,
  output logic [ITER_W-1:0]      iter_count,
  output logic                   timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_ITER,
    S_DONE
  } state_t;

  localparam logic [ITER_W-1:0] IterLimit = ITER_W'(MAX_ITER);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  winner_q, winner_d;
  logic              winner_valid_q, winner_valid_d;
  logic [ITER_W-1:0] iter_count_q, iter_count_d;
  logic              timeout_q, timeout_d;

  function automatic logic [IDX_W:0] popcount(input logic [NUM_NEURONS-1:0] v);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      cnt = cnt + {{IDX_W{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // Only meaningful when exactly one bit is set; returns the highest set index.
  function automatic logic [IDX_W-1:0] set_index(input logic [NUM_NEURONS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      iter_count_q   <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
      iter_count_q   <= iter_count_d;
      timeout_q      <= timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;
    iter_count_d   = iter_count_q;
    timeout_d      = timeout_q;
    load_init      = 1'b0;
    init_sel       = 1'b0;
    load_iter      = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d        = S_LOAD;
          winner_d       = '0;
          winner_valid_d = 1'b0;
          iter_count_d   = '0;
          timeout_d      = 1'b0;
        end
      end
      S_LOAD: begin
        load_init = 1'b1;
        init_sel  = 1'b1;
        state_d   = S_CHECK;
      end
      S_CHECK: begin
        // Single survivor wins over an exhausted iteration budget.
        if (popcount(nonzero) == (IDX_W+1)'(1)) begin
          state_d        = S_DONE;
          winner_d       = set_index(nonzero);
          winner_valid_d = 1'b1;
        end else if (popcount(nonzero) == '0) begin
          state_d        = S_DONE;
          winner_d       = '0;
          winner_valid_d = 1'b0;
`ifdef MAXNET_CTRL_TIMEOUT_EN
        end else if (iter_count_q == IterLimit) begin
          state_d        = S_DONE;
          timeout_d      = 1'b1;
          winner_valid_d = 1'b0;
`endif
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        load_iter    = 1'b1;
        iter_count_d = sat_inc(iter_count_q);
        state_d      = S_CHECK;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifndef MAXNET_CTRL_TIMEOUT_EN
  logic unused_iter_limit;
  assign unused_iter_limit = ^IterLimit;
`endif

  assign winner       = winner_q;
  assign winner_valid = winner_valid_q;
  assign iter_count   = iter_count_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Randomized bench for maxnet_controller; expected timing and results come from a run-level model.
module tb_maxnet_controller;
  localparam int NN   = 4;
  localparam int IW   = 2;
  localparam int ITW  = 8;
  localparam int MAXI = 3;
`ifdef MAXNET_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          start;
  logic [NN-1:0] nonzero;
  logic          load_init, init_sel, load_iter, busy, done;
  logic [IW-1:0] winner;
  logic          winner_valid;
  logic [ITW-1:0] iter_count;
  logic          timeout;

  int checks = 0;
  int errors = 0;
  logic [NN-1:0] vq[$];

  maxnet_controller #(
    .NUM_NEURONS(NN), .IDX_W(IW), .ITER_W(ITW), .MAX_ITER(MAXI)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .nonzero(nonzero),
    .load_init(load_init), .init_sel(init_sel), .load_iter(load_iter),
    .busy(busy), .done(done), .winner(winner), .winner_valid(winner_valid),
    .iter_count(iter_count), .timeout(timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Runs one transaction: CHECK number j sees vq[j] (last entry repeats); other cycles get noise.
  task automatic run_and_check(input string name, input bit stray);
    int k, d, pc, exp_it;
    logic [NN-1:0] v;
    logic [IW-1:0] fw;
    bit fv, ft, chk;
    logic [3:0] exp_s, got_s;
    logic [IW+1:0] exp_r, got_r;
    k = 0; fw = '0; fv = 0; ft = 0;
    forever begin
      v  = vq[(k < vq.size()) ? k : vq.size() - 1];
      pc = $countones(v);
      if (pc == 1) begin
        for (int i = 0; i < NN; i++) if (v[i]) fw = IW'(i);
        fv = 1;
        break;
      end else if (pc == 0) begin
        break;
      end else if (TO_EN && k == MAXI) begin
        ft = 1;
        break;
      end
      k++;
    end
    d = 3 + 2 * k;
    for (int c = 0; c <= d + 1; c++) begin
      @(negedge clock);
      if (c >= 1) begin
        exp_s = {c == 1, (c >= 3 && c < d && c % 2 == 1), c <= d, c == d};
        got_s = {load_init, load_iter, busy, done};
        checks++;
        if (got_s !== exp_s) begin
          errors++;
          $display("FAIL %s strobes cycle %0d: got %b want %b", name, c, got_s, exp_s);
        end
        if (c == 1) exp_it = 0;
        else if (c < d) exp_it = (c % 2 == 0) ? (c - 2) / 2 : (c - 3) / 2;
        else exp_it = k;
        if (exp_it > 255) exp_it = 255;
        checks++;
        if (iter_count !== ITW'(exp_it)) begin
          errors++;
          $display("FAIL %s iter_count cycle %0d: got %0d want %0d", name, c, iter_count, exp_it);
        end
        exp_r = (c >= d) ? {fv, fw, ft} : '0;
        got_r = {winner_valid, winner, timeout};
        checks++;
        if (got_r !== exp_r) begin
          errors++;
          $display("FAIL %s results cycle %0d: got %b want %b", name, c, got_r, exp_r);
        end
        chk = (c == 1) || (c >= 3 && c < d && c % 2 == 1);
        if (chk) begin
          checks++;
          if (init_sel !== (c == 1)) begin
            errors++;
            $display("FAIL %s init_sel cycle %0d: got %b want %b", name, c, init_sel, c == 1);
          end
        end
      end
      if (c == 0) start = 1'b1;
      else if (stray && c <= d) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      if (c >= 2 && c < d && c % 2 == 0) begin
        v = vq[((c - 2) / 2 < vq.size()) ? (c - 2) / 2 : vq.size() - 1];
        nonzero = v;
      end else begin
        nonzero = NN'($urandom_range(0, 15));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      start = 1'($urandom_range(0, 1));
      nonzero = NN'($urandom_range(0, 15));
      @(negedge clock);
      checks++;
      if ({load_init, init_sel, load_iter, busy, done, winner, winner_valid, iter_count, timeout} !== '0) begin
        errors++;
        $display("FAIL reset outputs: got %b %b %b %b %b %0d %b %0d %b want all 0", load_init, init_sel,
                 load_iter, busy, done, winner, winner_valid, iter_count, timeout);
      end
    end
    reset = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_directed();
    vq = {4'b0100};                   run_and_check("single", 0);
    vq = {4'b1111, 4'b0011, 4'b0010}; run_and_check("iterate", 0);
    vq = {4'b0000};                   run_and_check("allzero", 0);
  endtask

  task automatic test_timeout();
`ifdef MAXNET_CTRL_TIMEOUT_EN
    vq = {4'b1100};
    run_and_check("timeout", 0);
`else
    @(negedge clock);
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      start = 1'b0;
      nonzero = 4'b1100;
      checks++;
      if ({busy, load_iter, done} !== {1'b1, (c >= 3 && c % 2 == 1), 1'b0}) begin
        errors++;
        $display("FAIL nolimit cycle %0d: busy/load_iter/done got %b%b%b", c, busy, load_iter, done);
      end
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    vq = {};
    for (int i = 0; i < 300; i++) vq.push_back(4'b1111);
    vq.push_back(4'b0001);
    run_and_check("saturate", 0);
`endif
  endtask

  task automatic test_reset_mid_run();
    @(negedge clock);
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      start = (c < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      nonzero = 4'b1111;
      if (c == 7) begin
        checks++;
        if ({load_iter, iter_count} !== {1'b1, 8'd2}) begin
          errors++;
          $display("FAIL midreset pre: load_iter %b iter %0d want 1 2", load_iter, iter_count);
        end
        reset = 1'b1;
      end else if (c == 8) begin
        reset = 1'b0;
      end
      if (c >= 8) begin
        checks++;
        if ({load_init, load_iter, busy, done, winner_valid, iter_count, timeout} !== '0) begin
          errors++;
          $display("FAIL midreset cycle %0d: init %b iter %b busy %b done %b cnt %0d", c, load_init,
                   load_iter, busy, done, iter_count);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      if (c == 4) begin
        checks++;
        if ({busy, winner_valid, winner} !== {1'b0, 1'b1, 2'd2}) begin
          errors++;
          $display("FAIL b2b idle: busy %b valid %b winner %0d want 0 1 2", busy, winner_valid, winner);
        end
      end
      if (c == 5) begin
        checks++;
        if ({load_init, winner_valid, winner, iter_count} !== {1'b1, 1'b0, 2'd0, 8'd0}) begin
          errors++;
          $display("FAIL b2b restart: load_init %b valid %b winner %0d want 1 0 0", load_init, winner_valid, winner);
        end
      end
      if (c == 7) begin
        checks++;
        if ({done, winner_valid, winner} !== {1'b1, 1'b1, 2'd3}) begin
          errors++;
          $display("FAIL b2b second: done %b valid %b winner %0d want 1 1 3", done, winner_valid, winner);
        end
      end
      start = (c <= 4);
      nonzero = (c == 2) ? 4'b0100 : (c == 6) ? 4'b1000 : NN'($urandom_range(0, 15));
    end
    start = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 10; r++) begin
      vq = {};
      n = $urandom_range(1, 6);
      for (int i = 0; i < n - 1; i++) vq.push_back(NN'($urandom_range(0, 15)));
      vq.push_back(NN'(1 << $urandom_range(0, 3)) & NN'($urandom_range(0, 15)));
      run_and_check("random", 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    nonzero = '0;
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
